// File: rtl/div_ratio_checker_if.sv
// Signal bundle between a divided-clock source/monitor harness and div_ratio_checker.
// The harness drives div_in/clr_err; the checker returns lock, error and phase-length status.
interface div_ratio_checker_if #(
  parameter int CW = 8
);
  logic          div_in;
  logic          clr_err;
  logic          lock;
  logic          err;
  logic [7:0]    err_count;
  logic [CW-1:0] last_high;
  logic [CW-1:0] last_low;

  modport master (
    output div_in, clr_err,
    input  lock, err, err_count, last_high, last_low
  );

  modport slave (
    input  div_in, clr_err,
    output lock, err, err_count, last_high, last_low
  );
endinterface

// File: rtl/div_ratio_checker.sv
// Measures high/low phase lengths of an even-ratio divided signal in clk cycles,
// declares lock after 2*LOCK_CNT good phases and flags/counts ratio or duty errors.
module div_ratio_checker #(
  parameter int DIV      = 12,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CW       = 8
) (
  input  logic               clk,
  input  logic               reset,
  inout  wire                VDD,
  inout  wire                VSS,
  div_ratio_checker_if.slave bus
);

  localparam int            H       = DIV / 2;
  localparam int            GW      = $clog2(2 * LOCK_CNT + 1);
  localparam logic [CW-1:0] RUN_MAX = '1;
  localparam logic [CW-1:0] OVR_LEN = CW'(H + TOL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(2 * LOCK_CNT - 1);
  localparam logic [GW-1:0] GOOD_FULL = GW'(2 * LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  // Power pins are carried through for netlist compatibility only.
  wire unused_pwr = VDD ^ VSS;

  state_t        state, state_nx;
  logic          prev;
  logic [CW-1:0] run_len, run_len_nx;
  logic [GW-1:0] good_cnt, good_nx;
  logic          lock_q, lock_nx;
  logic          err_q, err_nx;
  logic [7:0]    err_count_q, cnt_nx;
  logic [CW-1:0] last_high_q, last_high_nx;
  logic [CW-1:0] last_low_q, last_low_nx;
  logic          edge_det;
  logic          good_phase;

  function automatic logic [CW-1:0] sat_inc_run(input logic [CW-1:0] v);
    return (v == RUN_MAX) ? v : v + CW'(1);
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A phase that ran into counter saturation cannot be trusted, whatever TOL says.
  function automatic logic phase_ok(input logic [CW-1:0] len);
    int l;
    l = int'(len);
    return (len != RUN_MAX) && (l >= H - TOL) && (l <= H + TOL);
  endfunction

  assign edge_det   = (bus.div_in != prev);
  assign good_phase = phase_ok(run_len);
  assign run_len_nx = edge_det ? CW'(1) : sat_inc_run(run_len);

  always_comb begin
    state_nx     = state;
    good_nx      = good_cnt;
    lock_nx      = lock_q;
    err_nx       = 1'b0;
    last_high_nx = last_high_q;
    last_low_nx  = last_low_q;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_nx = ACQ;
          good_nx  = '0;
        end
      end
      ACQ: begin
        if (edge_det) begin
          if (prev) last_high_nx = run_len;
          else      last_low_nx  = run_len;
          if (!good_phase) begin
            good_nx = '0;
          end else if (good_cnt == GOOD_LAST) begin
            good_nx  = GOOD_FULL;
            state_nx = LOCKED;
            lock_nx  = 1'b1;
          end else begin
            good_nx = good_cnt + GW'(1);
          end
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (prev) last_high_nx = run_len;
          else      last_low_nx  = run_len;
          if (!good_phase) begin
            err_nx   = 1'b1;
            lock_nx  = 1'b0;
            good_nx  = '0;
            state_nx = ACQ;
          end
        end else if (run_len == OVR_LEN) begin
          // Phase is about to exceed H+TOL: flag now rather than at the late edge.
          err_nx   = 1'b1;
          lock_nx  = 1'b0;
          good_nx  = '0;
          state_nx = ACQ;
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = '0;
        lock_nx  = 1'b0;
      end
    endcase

    cnt_nx = err_count_q;
    if (bus.clr_err)  cnt_nx = err_nx ? 8'd1 : 8'd0;
    else if (err_nx)  cnt_nx = sat_inc_err(err_count_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev        <= 1'b0;
      run_len     <= '0;
      good_cnt    <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      last_high_q <= '0;
      last_low_q  <= '0;
    end else begin
      state       <= state_nx;
      prev        <= bus.div_in;
      run_len     <= run_len_nx;
      good_cnt    <= good_nx;
      lock_q      <= lock_nx;
      err_q       <= err_nx;
      err_count_q <= cnt_nx;
      last_high_q <= last_high_nx;
      last_low_q  <= last_low_nx;
    end
  end

  assign bus.lock      = lock_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.last_high = last_high_q;
  assign bus.last_low  = last_low_q;

endmodule
